rename_register_file: RTL and testbench

RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

---
 rtl/rename_register_file_pkg.sv | 24 ++
 rtl/rename_register_file_lookup.sv | 65 ++++++
 rtl/rename_register_file.sv | 150 +++++++++++++++
 tb/tb_rename_register_file.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_register_file_pkg.sv
// Shared constants and the rename-entry type for the rename register file.
package rename_register_file_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    // Tags are stored zero-extended to this width so the entry type can live here
    // independent of the ROB_WIDTH parameter of any one instance.
    localparam int TAG_MAX_WIDTH  = 16;

    typedef struct packed {
        logic                     busy;
        logic [TAG_MAX_WIDTH-1:0] tag;
    } rename_entry_t;

    function automatic logic [5:0] count_busy(input logic [REG_COUNT-1:0] busy_vec);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            n = n + {5'd0, busy_vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rename_register_file_lookup.sv
// Single operand lookup: x0, same-cycle forwarding from older issue slots and,
// when REGFILE_COMMIT_BYPASS_EN is defined, bypass of a matching commit.
module rename_lookup_port
    import rename_register_file_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ROB_WIDTH    = 4,
    parameter int ISSUE_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int SLOT         = 0
) (
    input  logic                                   ready_in,
    input  logic [REG_ADDR_WIDTH-1:0]              src_addr,
    input  logic [XLEN-1:0]                        stored_value,
    input  logic                                   stored_busy,
    input  logic [ROB_WIDTH-1:0]                   stored_tag,
    input  logic [ISSUE_WIDTH-1:0]                 rd_flag,
    input  logic [REG_ADDR_WIDTH*ISSUE_WIDTH-1:0]  rd_addr,
    input  logic [ROB_WIDTH*ISSUE_WIDTH-1:0]       rd_dest,
    input  logic [COMMIT_WIDTH-1:0]                commit_flag,
    input  logic [ROB_WIDTH*COMMIT_WIDTH-1:0]      commit_rob_id,
    input  logic [REG_ADDR_WIDTH*COMMIT_WIDTH-1:0] commit_addr,
    input  logic [XLEN*COMMIT_WIDTH-1:0]           commit_value,
    output logic [XLEN-1:0]                        value_out,
    output logic [ROB_WIDTH-1:0]                   rename_out,
    output logic                                   busy_out
);

`ifndef REGFILE_COMMIT_BYPASS_EN
    logic unused_commit;
    assign unused_commit = ^{ready_in, commit_flag, commit_rob_id, commit_addr, commit_value};
`endif

    // Priority: stored state < commit bypass < older-slot forward < x0.
    always_comb begin
        value_out  = stored_value;
        rename_out = stored_tag;
        busy_out   = stored_busy;
`ifdef REGFILE_COMMIT_BYPASS_EN
        for (int p = 0; p < COMMIT_WIDTH; p++) begin
            if (ready_in && commit_flag[p]
                && commit_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == src_addr
                && commit_rob_id[p*ROB_WIDTH +: ROB_WIDTH] == stored_tag) begin
                value_out = commit_value[p*XLEN +: XLEN];
                busy_out  = 1'b0;
            end
        end
`endif
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (i < SLOT && rd_flag[i]
                && rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == src_addr
                && src_addr != '0) begin
                value_out  = '0;
                rename_out = rd_dest[i*ROB_WIDTH +: ROB_WIDTH];
                busy_out   = 1'b1;
            end
        end
        if (src_addr == '0) begin
            value_out  = '0;
            rename_out = '0;
            busy_out   = 1'b0;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename (busy + ROB tag) state.
// Optional feature: define REGFILE_COMMIT_BYPASS_EN to make same-cycle commits
// visible to operand lookups.
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ROB_WIDTH    = 4,
    parameter int ISSUE_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                                   clockIn,
    input  logic                                   resetIn,
    input  logic                                   readyIn,
    input  logic                                   clearIn,
    input  logic [ISSUE_WIDTH-1:0]                 issueRdFlag,
    input  logic [REG_ADDR_WIDTH*ISSUE_WIDTH-1:0]  issueRdAddr,
    input  logic [ROB_WIDTH*ISSUE_WIDTH-1:0]       issueRdDest,
    input  logic [REG_ADDR_WIDTH*ISSUE_WIDTH-1:0]  issueRs1Addr,
    input  logic [REG_ADDR_WIDTH*ISSUE_WIDTH-1:0]  issueRs2Addr,
    output logic [XLEN*ISSUE_WIDTH-1:0]            rs1Value,
    output logic [XLEN*ISSUE_WIDTH-1:0]            rs2Value,
    output logic [ROB_WIDTH*ISSUE_WIDTH-1:0]       rs1Rename,
    output logic [ROB_WIDTH*ISSUE_WIDTH-1:0]       rs2Rename,
    output logic [ISSUE_WIDTH-1:0]                 rs1Busy,
    output logic [ISSUE_WIDTH-1:0]                 rs2Busy,
    input  logic [COMMIT_WIDTH-1:0]                commitFlag,
    input  logic [ROB_WIDTH*COMMIT_WIDTH-1:0]      commitRobId,
    input  logic [REG_ADDR_WIDTH*COMMIT_WIDTH-1:0] commitAddr,
    input  logic [XLEN*COMMIT_WIDTH-1:0]           commitValue,
    output logic [5:0]                             busyCount
);

    logic [XLEN-1:0]           value_q [REG_COUNT];
    logic [XLEN-1:0]           value_d [REG_COUNT];
    rename_entry_t             entry_q [REG_COUNT];
    rename_entry_t             entry_d [REG_COUNT];
    logic [5:0]                busy_count_q;
    logic [5:0]                busy_count_d;
    logic [REG_COUNT-1:0]      commit_clear;
    logic [REG_COUNT-1:0]      busy_vec;
    logic [REG_ADDR_WIDTH-1:0] commit_addr_w [COMMIT_WIDTH];
    logic [REG_ADDR_WIDTH-1:0] issue_addr_w  [ISSUE_WIDTH];

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit_addr
        assign commit_addr_w[gi] = commitAddr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end

    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_issue_addr
        assign issue_addr_w[gi] = issueRdAddr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end

    // Next state: commits write values and may retire busy; issue renames win over retirement.
    always_comb begin
        value_d      = value_q;
        entry_d      = entry_q;
        commit_clear = '0;
        if (readyIn) begin
            for (int p = 0; p < COMMIT_WIDTH; p++) begin
                if (commitFlag[p] && commit_addr_w[p] != '0) begin
                    value_d[commit_addr_w[p]] = commitValue[p*XLEN +: XLEN];
                    if (entry_q[commit_addr_w[p]].tag
                        == TAG_MAX_WIDTH'(commitRobId[p*ROB_WIDTH +: ROB_WIDTH])) begin
                        commit_clear[commit_addr_w[p]] = 1'b1;
                    end
                end
            end
            for (int r = 0; r < REG_COUNT; r++) begin
                if (commit_clear[r] || clearIn) begin
                    entry_d[r].busy = 1'b0;
                end
            end
            if (!clearIn) begin
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    if (issueRdFlag[i] && issue_addr_w[i] != '0) begin
                        entry_d[issue_addr_w[i]].busy = 1'b1;
                        entry_d[issue_addr_w[i]].tag  =
                            TAG_MAX_WIDTH'(issueRdDest[i*ROB_WIDTH +: ROB_WIDTH]);
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_busy_vec
        assign busy_vec[gi] = entry_d[gi].busy;
    end

    assign busy_count_d = count_busy(busy_vec);

    // State registers with asynchronous clear.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                value_q[r] <= '0;
                entry_q[r] <= '0;
            end
            busy_count_q <= '0;
        end else begin
            value_q      <= value_d;
            entry_q      <= entry_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busyCount = busy_count_q;

    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
        logic [REG_ADDR_WIDTH-1:0] rs1_addr;
        logic [REG_ADDR_WIDTH-1:0] rs2_addr;
        logic [ROB_WIDTH-1:0]      rs1_tag;
        logic [ROB_WIDTH-1:0]      rs2_tag;

        assign rs1_addr = issueRs1Addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign rs2_addr = issueRs2Addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign rs1_tag  = entry_q[rs1_addr].tag[ROB_WIDTH-1:0];
        assign rs2_tag  = entry_q[rs2_addr].tag[ROB_WIDTH-1:0];

        rename_lookup_port #(
            .XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH),
            .COMMIT_WIDTH(COMMIT_WIDTH), .SLOT(gi)
        ) u_rs1 (
            .ready_in(readyIn), .src_addr(rs1_addr),
            .stored_value(value_q[rs1_addr]), .stored_busy(entry_q[rs1_addr].busy),
            .stored_tag(rs1_tag),
            .rd_flag(issueRdFlag), .rd_addr(issueRdAddr), .rd_dest(issueRdDest),
            .commit_flag(commitFlag), .commit_rob_id(commitRobId),
            .commit_addr(commitAddr), .commit_value(commitValue),
            .value_out(rs1Value[gi*XLEN +: XLEN]),
            .rename_out(rs1Rename[gi*ROB_WIDTH +: ROB_WIDTH]),
            .busy_out(rs1Busy[gi])
        );

        rename_lookup_port #(
            .XLEN(XLEN), .ROB_WIDTH(ROB_WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH),
            .COMMIT_WIDTH(COMMIT_WIDTH), .SLOT(gi)
        ) u_rs2 (
            .ready_in(readyIn), .src_addr(rs2_addr),
            .stored_value(value_q[rs2_addr]), .stored_busy(entry_q[rs2_addr].busy),
            .stored_tag(rs2_tag),
            .rd_flag(issueRdFlag), .rd_addr(issueRdAddr), .rd_dest(issueRdDest),
            .commit_flag(commitFlag), .commit_rob_id(commitRobId),
            .commit_addr(commitAddr), .commit_value(commitValue),
            .value_out(rs2Value[gi*XLEN +: XLEN]),
            .rename_out(rs2Rename[gi*ROB_WIDTH +: ROB_WIDTH]),
            .busy_out(rs2Busy[gi])
        );
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_rename_register_file;

    localparam int XLEN = 32;
    localparam int RW   = 4;
    localparam int IW   = 2;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready;
    logic            clr;
    logic [IW-1:0]   rd_flag;
    logic [5*IW-1:0] rd_addr;
    logic [RW*IW-1:0] rd_dest;
    logic [5*IW-1:0] rs1_addr;
    logic [5*IW-1:0] rs2_addr;
    logic [XLEN*IW-1:0] rs1_val;
    logic [XLEN*IW-1:0] rs2_val;
    logic [RW*IW-1:0] rs1_ren;
    logic [RW*IW-1:0] rs2_ren;
    logic [IW-1:0]   rs1_busy;
    logic [IW-1:0]   rs2_busy;
    logic [CW-1:0]   c_flag;
    logic [RW*CW-1:0] c_rob;
    logic [5*CW-1:0] c_addr;
    logic [XLEN*CW-1:0] c_val;
    logic [5:0]      busy_count;

    int errors = 0;
    int checks = 0;

    // Reference model: plain per-register arrays.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    rename_register_file #(.XLEN(XLEN), .ROB_WIDTH(RW), .ISSUE_WIDTH(IW), .COMMIT_WIDTH(CW)) dut (
        .clockIn(clk), .resetIn(rst), .readyIn(ready), .clearIn(clr),
        .issueRdFlag(rd_flag), .issueRdAddr(rd_addr), .issueRdDest(rd_dest),
        .issueRs1Addr(rs1_addr), .issueRs2Addr(rs2_addr),
        .rs1Value(rs1_val), .rs2Value(rs2_val), .rs1Rename(rs1_ren), .rs2Rename(rs2_ren),
        .rs1Busy(rs1_busy), .rs2Busy(rs2_busy),
        .commitFlag(c_flag), .commitRobId(c_rob), .commitAddr(c_addr), .commitValue(c_val),
        .busyCount(busy_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        ready = 1'b1; clr = 1'b0;
        rd_flag = '0; rd_addr = '0; rd_dest = '0; rs1_addr = '0; rs2_addr = '0;
        c_flag = '0; c_rob = '0; c_addr = '0; c_val = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Apply one clock edge worth of architectural rules to the model.
    task automatic model_edge();
        logic retire [32];
        logic [4:0] a;
        if (!ready) return;
        for (int r = 0; r < 32; r++) retire[r] = 1'b0;
        for (int p = 0; p < CW; p++) begin
            a = c_addr[p*5 +: 5];
            if (c_flag[p] && a != 0) begin
                m_val[a] = c_val[p*XLEN +: XLEN];
                if (m_tag[a] == c_rob[p*RW +: RW]) retire[a] = 1'b1;
            end
        end
        for (int r = 0; r < 32; r++) if (retire[r] || clr) m_busy[r] = 1'b0;
        if (!clr) begin
            for (int i = 0; i < IW; i++) begin
                a = rd_addr[i*5 +: 5];
                if (rd_flag[i] && a != 0) begin
                    m_busy[a] = 1'b1;
                    m_tag[a]  = rd_dest[i*RW +: RW];
                end
            end
        end
    endtask

    // Expected lookup for slot j reading address a under the current inputs.
    task automatic exp_lookup(input int j, input logic [4:0] a,
                              output logic [31:0] v, output logic [3:0] t, output logic b);
        logic fwd = 1'b0;
        v = m_val[a]; t = m_tag[a]; b = m_busy[a];
        for (int i = 0; i < j; i++) begin
            if (rd_flag[i] && rd_addr[i*5 +: 5] == a) begin
                fwd = 1'b1; v = '0; b = 1'b1; t = rd_dest[i*RW +: RW];
            end
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (!fwd && ready) begin
            for (int p = 0; p < CW; p++) begin
                if (c_flag[p] && c_addr[p*5 +: 5] == a && c_rob[p*RW +: RW] == m_tag[a]) begin
                    v = c_val[p*XLEN +: XLEN]; b = 1'b0;
                end
            end
        end
`endif
        if (a == 0) begin
            v = '0; t = '0; b = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #12 rst = 1'b0;
        rs1_addr[4:0] = 5'd5;
        #1;
        checks++; if (rs1_val[31:0] !== 32'd0) begin errors++; $display("FAIL reset_value got %0h expected 0", rs1_val[31:0]); end
        checks++; if (rs1_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", rs1_busy[0]); end
        checks++; if (rs1_ren[3:0] !== 4'd0) begin errors++; $display("FAIL reset_rename got %0h expected 0", rs1_ren[3:0]); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", busy_count); end
        $display("test_reset: x5 value=%0h busy=%0b rename=%0h count=%0d", rs1_val[31:0], rs1_busy[0], rs1_ren[3:0], busy_count);
    endtask

    task automatic test_forward();
        idle_inputs();
        rd_flag[0] = 1'b1; rd_addr[4:0] = 5'd3; rd_dest[3:0] = 4'd2;
        rs1_addr[4:0] = 5'd3; rs1_addr[9:5] = 5'd3;
        #1;
        checks++; if (rs1_busy[1] !== 1'b1) begin errors++; $display("FAIL fwd_busy got %0b expected 1", rs1_busy[1]); end
        checks++; if (rs1_ren[7:4] !== 4'd2) begin errors++; $display("FAIL fwd_rename got %0h expected 2", rs1_ren[7:4]); end
        checks++; if (rs1_val[63:32] !== 32'd0) begin errors++; $display("FAIL fwd_value got %0h expected 0", rs1_val[63:32]); end
        checks++; if (rs1_busy[0] !== 1'b0) begin errors++; $display("FAIL fwd_slot0_busy got %0b expected 0", rs1_busy[0]); end
        step();
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL fwd_count got %0d expected 1", busy_count); end
        $display("test_forward: slot1 busy=%0b rename=%0h count=%0d", rs1_busy[1], rs1_ren[7:4], busy_count);
    endtask

    task automatic test_commit();
        idle_inputs();
        c_flag[0] = 1'b1; c_addr[4:0] = 5'd3; c_rob[3:0] = 4'd2; c_val[31:0] = 32'hDEADBEEF;
        rs1_addr[4:0] = 5'd3;
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        checks++; if (rs1_val[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_value got %0h expected deadbeef", rs1_val[31:0]); end
        checks++; if (rs1_busy[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy got %0b expected 0", rs1_busy[0]); end
`else
        checks++; if (rs1_val[31:0] !== 32'd0) begin errors++; $display("FAIL precommit_value got %0h expected 0", rs1_val[31:0]); end
        checks++; if (rs1_busy[0] !== 1'b1) begin errors++; $display("FAIL precommit_busy got %0b expected 1", rs1_busy[0]); end
`endif
        step();
        idle_inputs();
        rs1_addr[4:0] = 5'd3;
        #1;
        checks++; if (rs1_val[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_value got %0h expected deadbeef", rs1_val[31:0]); end
        checks++; if (rs1_busy[0] !== 1'b0) begin errors++; $display("FAIL commit_busy got %0b expected 0", rs1_busy[0]); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL commit_count got %0d expected 0", busy_count); end
        $display("test_commit: x3 value=%0h busy=%0b count=%0d", rs1_val[31:0], rs1_busy[0], busy_count);
    endtask

    task automatic test_stale_commit();
        idle_inputs();
        rd_flag[0] = 1'b1; rd_addr[4:0] = 5'd3; rd_dest[3:0] = 4'd5;
        step();
        idle_inputs();
        c_flag[1] = 1'b1; c_addr[9:5] = 5'd3; c_rob[7:4] = 4'd2; c_val[63:32] = 32'd7;
        step();
        idle_inputs();
        rs2_addr[9:5] = 5'd3;
        #1;
        checks++; if (rs2_val[63:32] !== 32'd7) begin errors++; $display("FAIL stale_value got %0h expected 7", rs2_val[63:32]); end
        checks++; if (rs2_busy[1] !== 1'b1) begin errors++; $display("FAIL stale_busy got %0b expected 1", rs2_busy[1]); end
        checks++; if (rs2_ren[7:4] !== 4'd5) begin errors++; $display("FAIL stale_rename got %0h expected 5", rs2_ren[7:4]); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL stale_count got %0d expected 1", busy_count); end
        $display("test_stale_commit: x3 value=%0h busy=%0b rename=%0h", rs2_val[63:32], rs2_busy[1], rs2_ren[7:4]);
    endtask

    task automatic test_clear();
        idle_inputs();
        clr = 1'b1;
        c_flag = 2'b11; c_addr = {5'd4, 5'd4}; c_rob = {4'd1, 4'd1}; c_val = {32'd2, 32'd1};
        rd_flag[0] = 1'b1; rd_addr[4:0] = 5'd6; rd_dest[3:0] = 4'd9;
        step();
        idle_inputs();
        rs1_addr[4:0] = 5'd4; rs2_addr[4:0] = 5'd6; rs1_addr[9:5] = 5'd3;
        #1;
        checks++; if (rs1_val[31:0] !== 32'd2) begin errors++; $display("FAIL clear_value got %0h expected 2", rs1_val[31:0]); end
        checks++; if (rs2_busy[0] !== 1'b0) begin errors++; $display("FAIL clear_x6_busy got %0b expected 0", rs2_busy[0]); end
        checks++; if (rs1_busy[1] !== 1'b0) begin errors++; $display("FAIL clear_x3_busy got %0b expected 0", rs1_busy[1]); end
        checks++; if (rs1_ren[7:4] !== 4'd5) begin errors++; $display("FAIL clear_tag_kept got %0h expected 5", rs1_ren[7:4]); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL clear_count got %0d expected 0", busy_count); end
        $display("test_clear: x4=%0h x6 busy=%0b count=%0d", rs1_val[31:0], rs2_busy[0], busy_count);
    endtask

    task automatic test_freeze();
        idle_inputs();
        rd_flag[0] = 1'b1; rd_addr[4:0] = 5'd9; rd_dest[3:0] = 4'd1;
        step();
        idle_inputs();
        ready = 1'b0; clr = 1'b1;
        rd_flag[1] = 1'b1; rd_addr[9:5] = 5'd10; rd_dest[7:4] = 4'd3;
        c_flag[0] = 1'b1; c_addr[4:0] = 5'd9; c_rob[3:0] = 4'd1; c_val[31:0] = 32'd55;
        step();
        idle_inputs();
        rs1_addr[4:0] = 5'd9; rs2_addr[4:0] = 5'd10;
        #1;
        checks++; if (rs1_busy[0] !== 1'b1) begin errors++; $display("FAIL freeze_busy got %0b expected 1", rs1_busy[0]); end
        checks++; if (rs1_val[31:0] !== 32'd0) begin errors++; $display("FAIL freeze_value got %0h expected 0", rs1_val[31:0]); end
        checks++; if (rs2_busy[0] !== 1'b0) begin errors++; $display("FAIL freeze_issue got %0b expected 0", rs2_busy[0]); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL freeze_count got %0d expected 1", busy_count); end
        $display("test_freeze: x9 busy=%0b x10 busy=%0b count=%0d", rs1_busy[0], rs2_busy[0], busy_count);
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic [3:0]  et;
        logic        eb;
        logic [4:0]  a;
        int          bad;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            ready = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < IW; i++) begin
                rd_flag[i]        = $urandom_range(0, 1);
                rd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
                rd_dest[i*RW +: RW] = 4'($urandom);
                rs1_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
                rs2_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
            end
            for (int p = 0; p < CW; p++) begin
                a = 5'($urandom_range(0, 7));
                c_flag[p]          = $urandom_range(0, 1);
                c_addr[p*5 +: 5]   = a;
                c_rob[p*RW +: RW]  = ($urandom_range(0, 1) != 0) ? m_tag[a] : 4'($urandom);
                c_val[p*XLEN +: XLEN] = $urandom;
            end
            #1;
            bad = 0;
            for (int j = 0; j < IW; j++) begin
                exp_lookup(j, rs1_addr[j*5 +: 5], ev, et, eb);
                checks++;
                if (rs1_val[j*XLEN +: XLEN] !== ev || rs1_ren[j*RW +: RW] !== et || rs1_busy[j] !== eb) begin
                    errors++; bad++;
                    $display("FAIL rand_rs1 cyc=%0d slot=%0d got v=%0h t=%0h b=%0b expected v=%0h t=%0h b=%0b",
                             n, j, rs1_val[j*XLEN +: XLEN], rs1_ren[j*RW +: RW], rs1_busy[j], ev, et, eb);
                end
                exp_lookup(j, rs2_addr[j*5 +: 5], ev, et, eb);
                checks++;
                if (rs2_val[j*XLEN +: XLEN] !== ev || rs2_ren[j*RW +: RW] !== et || rs2_busy[j] !== eb) begin
                    errors++; bad++;
                    $display("FAIL rand_rs2 cyc=%0d slot=%0d got v=%0h t=%0h b=%0b expected v=%0h t=%0h b=%0b",
                             n, j, rs2_val[j*XLEN +: XLEN], rs2_ren[j*RW +: RW], rs2_busy[j], ev, et, eb);
                end
            end
            step();
            checks++;
            if (int'(busy_count) != model_count()) begin
                errors++; bad++;
                $display("FAIL rand_count cyc=%0d got %0d expected %0d", n, busy_count, model_count());
            end
            $display("test_random cyc=%0d ready=%0b clear=%0b count=%0d mismatches=%0d", n, ready, clr, busy_count, bad);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        rd_flag[0] = 1'b1; rd_addr[4:0] = 5'd7; rd_dest[3:0] = 4'd3;
        step();
        idle_inputs();
        rs1_addr[4:0] = 5'd7; rs2_addr[4:0] = 5'd4;
        #1;
        checks++; if (rs1_busy[0] !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got %0b expected 1", rs1_busy[0]); end
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (rs1_busy[0] !== 1'b0) begin errors++; $display("FAIL areset_busy got %0b expected 0", rs1_busy[0]); end
        checks++; if (rs1_ren[3:0] !== 4'd0) begin errors++; $display("FAIL areset_rename got %0h expected 0", rs1_ren[3:0]); end
        checks++; if (rs2_val[31:0] !== 32'd0) begin errors++; $display("FAIL areset_value got %0h expected 0", rs2_val[31:0]); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL areset_count got %0d expected 0", busy_count); end
        $display("test_async_reset: x7 busy=%0b x4=%0h count=%0d", rs1_busy[0], rs2_val[31:0], busy_count);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_commit();
        test_stale_commit();
        test_clear();
        test_freeze();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
